// File: rtl/addr_mode_sequencer.sv
//============================================================================
// Module      : addr_mode_sequencer
// Description : Machine-cycle FSM that steps the address bus through one
//               addressing-mode access (IMM, ABS, ABS_X, ABS_Y, STACK).
//               Drives the high/low address mux selects, the operand load
//               and PC-increment strobes, and reports busy/done.
//
// Ports       : fclk          system clock
//               reset         synchronous active-high reset
//               q[1:0]        machine-cycle phase, tick = (q == 3)
//               be            bus enable, low freezes the sequencer
//               start         new access request (IDLE, on a tick)
//               mode[2:0]     0 IMM, 1 ABS, 2 ABS_X, 3 ABS_Y, 4 STACK
//               page_cross    index-add carry, used on the IDX tick
//               hmode_select  high-byte source select (registered)
//               lmode_select  low-byte source select (registered)
//               idx_sel       ALU index operand, 0 = X, 1 = Y
//               pc_inc, latch_lo_en, latch_hi_en, alu_index_req, fix_hi
//                             one-fclk strobes on the tick of a state
//               busy          state != IDLE
//               done          one-fclk pulse after the access completes
//
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module addr_mode_sequencer #(
    parameter logic [2:0] IDLE_HSEL = 3'b101,
    parameter logic [2:0] IDLE_LSEL = 3'b101
) (
    input  logic       fclk,
    input  logic       reset,
    input  logic [1:0] q,
    input  logic       be,
    input  logic       start,
    input  logic [2:0] mode,
    input  logic       page_cross,
    output logic [2:0] hmode_select,
    output logic [2:0] lmode_select,
    output logic       idx_sel,
    output logic       pc_inc,
    output logic       latch_lo_en,
    output logic       latch_hi_en,
    output logic       alu_index_req,
    output logic       fix_hi,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OPER = 3'd1,
        S_LO   = 3'd2,
        S_HI   = 3'd3,
        S_EFF  = 3'd4,
        S_IDX  = 3'd5,
        S_FIX  = 3'd6,
        S_STK  = 3'd7
    } state_t;

    localparam logic [2:0] c_MODE_ABS   = 3'd1;
    localparam logic [2:0] c_MODE_ABSX  = 3'd2;
    localparam logic [2:0] c_MODE_ABSY  = 3'd3;
    localparam logic [2:0] c_MODE_STACK = 3'd4;

    localparam logic [2:0] c_SEL_LATCH  = 3'b110;
    localparam logic [2:0] c_SEL_ALU    = 3'b011;
    localparam logic [2:0] c_SEL_STACK  = 3'b010;

    state_t     r_state_q,   w_state_d;
    logic       r_indexed_q, w_indexed_d;
    logic       r_idx_sel_q, w_idx_sel_d;
    logic [2:0] r_hsel_q,    w_hsel_d;
    logic [2:0] r_lsel_q,    w_lsel_d;
    logic       r_done_q,    w_done_d;
    logic       w_step;

    // The sequencer only advances on an enabled machine-cycle boundary.
    assign w_step = (q == 2'b11) && be;

    always_comb begin
        w_state_d   = r_state_q;
        w_indexed_d = r_indexed_q;
        w_idx_sel_d = r_idx_sel_q;
        if (w_step) begin
            case (r_state_q)
                S_IDLE: begin
                    if (start) begin
                        w_idx_sel_d = (mode == c_MODE_ABSY);
                        w_indexed_d = (mode == c_MODE_ABSX) || (mode == c_MODE_ABSY);
                        case (mode)
                            c_MODE_ABS,
                            c_MODE_ABSX,
                            c_MODE_ABSY:  w_state_d = S_LO;
                            c_MODE_STACK: w_state_d = S_STK;
                            default:      w_state_d = S_OPER;  // IMM and undefined modes
                        endcase
                    end
                end
                S_LO:    w_state_d = S_HI;
                S_HI:    w_state_d = r_indexed_q ? S_IDX : S_EFF;
                S_IDX:   w_state_d = page_cross ? S_FIX : S_IDLE;
                default: w_state_d = S_IDLE;  // OPER, EFF, FIX, STK all finish here
            endcase
        end
    end

    // Selects are decoded from the next state and registered with it, so
    // they switch on the tick edge and are stable for the whole machine cycle.
    always_comb begin
        w_hsel_d = IDLE_HSEL;
        w_lsel_d = IDLE_LSEL;
        case (w_state_d)
            S_EFF: begin
                w_hsel_d = c_SEL_LATCH;
                w_lsel_d = c_SEL_LATCH;
            end
            S_IDX, S_FIX: begin
                w_hsel_d = c_SEL_LATCH;
                w_lsel_d = c_SEL_ALU;
            end
            S_STK: begin
                w_hsel_d = c_SEL_STACK;
                w_lsel_d = c_SEL_STACK;
            end
            default: begin
                w_hsel_d = IDLE_HSEL;
                w_lsel_d = IDLE_LSEL;
            end
        endcase
    end

    assign w_done_d = w_step && (r_state_q != S_IDLE) && (w_state_d == S_IDLE);

    always_ff @(posedge fclk) begin
        if (reset) begin
            r_state_q   <= S_IDLE;
            r_indexed_q <= 1'b0;
            r_idx_sel_q <= 1'b0;
            r_hsel_q    <= IDLE_HSEL;
            r_lsel_q    <= IDLE_LSEL;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_indexed_q <= w_indexed_d;
            r_idx_sel_q <= w_idx_sel_d;
            r_hsel_q    <= w_hsel_d;
            r_lsel_q    <= w_lsel_d;
            r_done_q    <= w_done_d;
        end
    end

    assign hmode_select  = r_hsel_q;
    assign lmode_select  = r_lsel_q;
    assign idx_sel       = r_idx_sel_q;
    assign busy          = (r_state_q != S_IDLE);
    assign done          = r_done_q;

    assign pc_inc        = w_step && ((r_state_q == S_OPER) || (r_state_q == S_LO) ||
                                      (r_state_q == S_HI));
    assign latch_lo_en   = w_step && ((r_state_q == S_OPER) || (r_state_q == S_LO));
    assign latch_hi_en   = w_step && (r_state_q == S_HI);
    assign alu_index_req = w_step && (r_state_q == S_IDX);
    assign fix_hi        = w_step && (r_state_q == S_FIX);

endmodule

`default_nettype wire

// File: tb/tb_addr_mode_sequencer.sv
//============================================================================
// Module      : tb_addr_mode_sequencer
// Description : Directed scoreboard bench for addr_mode_sequencer. Each
//               issued access pushes a hand-computed expected record; the
//               monitor accumulates strobes, per-machine-cycle selects and
//               busy length, then pops and compares when done pulses.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_addr_mode_sequencer;

    logic       fclk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] q = 2'd0;
    logic       be = 1'b1;
    logic       start = 1'b0;
    logic [2:0] mode = 3'd0;
    logic       page_cross = 1'b0;
    logic [2:0] hmode_select;
    logic [2:0] lmode_select;
    logic       idx_sel;
    logic       pc_inc;
    logic       latch_lo_en;
    logic       latch_hi_en;
    logic       alu_index_req;
    logic       fix_hi;
    logic       busy;
    logic       done;

    addr_mode_sequencer #(
        .IDLE_HSEL (3'b101),
        .IDLE_LSEL (3'b101)
    ) dut (
        .fclk          (fclk),
        .reset         (reset),
        .q             (q),
        .be            (be),
        .start         (start),
        .mode          (mode),
        .page_cross    (page_cross),
        .hmode_select  (hmode_select),
        .lmode_select  (lmode_select),
        .idx_sel       (idx_sel),
        .pc_inc        (pc_inc),
        .latch_lo_en   (latch_lo_en),
        .latch_hi_en   (latch_hi_en),
        .alu_index_req (alu_index_req),
        .fix_hi        (fix_hi),
        .busy          (busy),
        .done          (done)
    );

    // Clock plus free-running phase counter; q advances just after each
    // rising edge so every edge sees a stable phase value.
    initial begin
        forever begin
            #5 fclk = 1'b1;
            #1 q = q + 2'd1;
            #4 fclk = 1'b0;
        end
    end

    typedef struct {
        int          busy_cyc;
        logic [63:0] trace;
        int          nsel;
        int          pc;
        int          lo;
        int          hi;
        int          alu;
        int          fix;
        logic        idx;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    int          a_busy, a_nsel, a_pc, a_lo, a_hi, a_alu, a_fix;
    logic [63:0] a_trace;

    function automatic exp_t mk(input int b, input logic [63:0] t, input int ns,
                                input int p, input int l, input int h,
                                input int a, input int f, input logic ix);
        exp_t r;
        r.busy_cyc = b; r.trace = t; r.nsel = ns; r.pc = p; r.lo = l;
        r.hi = h; r.alu = a; r.fix = f; r.idx = ix;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_acc();
        a_busy = 0; a_nsel = 0; a_pc = 0; a_lo = 0; a_hi = 0;
        a_alu = 0; a_fix = 0; a_trace = 64'd0;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge fclk) begin
        if (reset) begin
            clear_acc();
        end else begin
            if (busy) begin
                a_busy++;
                if (q == 2'd0) begin
                    a_trace = {a_trace[57:0], hmode_select, lmode_select};
                    a_nsel++;
                end
            end
            a_pc  += int'(pc_inc);
            a_lo  += int'(latch_lo_en);
            a_hi  += int'(latch_hi_en);
            a_alu += int'(alu_index_req);
            a_fix += int'(fix_hi);
            if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending access (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("busy_cycles", 64'(a_busy), 64'(e.busy_cyc));
                    chk("select_trace", a_trace, e.trace);
                    chk("select_cycles", 64'(a_nsel), 64'(e.nsel));
                    chk("pc_inc_count", 64'(a_pc), 64'(e.pc));
                    chk("latch_lo_count", 64'(a_lo), 64'(e.lo));
                    chk("latch_hi_count", 64'(a_hi), 64'(e.hi));
                    chk("alu_req_count", 64'(a_alu), 64'(e.alu));
                    chk("fix_hi_count", 64'(a_fix), 64'(e.fix));
                    chk("idx_sel", 64'(idx_sel), 64'(e.idx));
                end
                clear_acc();
            end
        end
    end

    task automatic wait_tick_setup();
        @(negedge fclk);
        while (q != 2'd3) @(negedge fclk);
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge fclk);
        while (!done && t < 200) begin
            @(negedge fclk);
            t++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    // Issue one access; optional be stall of 8 fclk in LO and optional
    // stray start request while busy.
    task automatic run_access(input logic [2:0] m, input logic pcx, input logic stall,
                              input logic stray, input exp_t ex);
        page_cross = pcx;
        wait_tick_setup();
        sb.push_back(ex);
        start = 1'b1;
        mode  = m;
        @(posedge fclk);
        #2 start = 1'b0;
        if (stall) begin
            be = 1'b0;
            repeat (8) @(posedge fclk);
            #2 be = 1'b1;
        end
        if (stray) begin
            wait_tick_setup();
            start = 1'b1;
            mode  = 3'd4;
            @(posedge fclk);
            #2 start = 1'b0;
        end
        wait_done();
    endtask

    // Octal select pairs: 55 = PCH/PCL, 66 = latches, 63 = latch A/ALU, 22 = page 01/SP
    initial begin
        int dn;
        clear_acc();
        repeat (3) @(posedge fclk);
        #2 reset = 1'b0;
        @(negedge fclk);
        chk("rst_hsel", 64'(hmode_select), 64'd5);
        chk("rst_lsel", 64'(lmode_select), 64'd5);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_idx_sel", 64'(idx_sel), 64'd0);

        run_access(3'd0, 1'b0, 1'b0, 1'b0, mk(4,  64'({6'o55}), 1, 1, 1, 0, 0, 0, 1'b0));
        run_access(3'd1, 1'b1, 1'b0, 1'b0, mk(12, 64'({6'o55, 6'o55, 6'o66}), 3, 2, 1, 1, 0, 0, 1'b0));
        run_access(3'd3, 1'b1, 1'b0, 1'b0, mk(16, 64'({6'o55, 6'o55, 6'o63, 6'o63}), 4, 2, 1, 1, 1, 1, 1'b1));
        run_access(3'd3, 1'b0, 1'b0, 1'b0, mk(12, 64'({6'o55, 6'o55, 6'o63}), 3, 2, 1, 1, 1, 0, 1'b1));
        run_access(3'd2, 1'b1, 1'b0, 1'b0, mk(16, 64'({6'o55, 6'o55, 6'o63, 6'o63}), 4, 2, 1, 1, 1, 1, 1'b0));
        run_access(3'd4, 1'b1, 1'b0, 1'b0, mk(4,  64'({6'o22}), 1, 0, 0, 0, 0, 0, 1'b0));
        run_access(3'd6, 1'b0, 1'b0, 1'b0, mk(4,  64'({6'o55}), 1, 1, 1, 0, 0, 0, 1'b0));
        run_access(3'd1, 1'b0, 1'b1, 1'b0,
                   mk(20, 64'({6'o55, 6'o55, 6'o55, 6'o55, 6'o66}), 5, 2, 1, 1, 0, 0, 1'b0));
        run_access(3'd1, 1'b0, 1'b0, 1'b1, mk(12, 64'({6'o55, 6'o55, 6'o66}), 3, 2, 1, 1, 0, 0, 1'b0));

        // Abort an ABS_Y access in HI with a two-cycle reset: no record pushed.
        page_cross = 1'b1;
        wait_tick_setup();
        start = 1'b1;
        mode  = 3'd3;
        @(posedge fclk);
        #2 start = 1'b0;
        repeat (5) @(posedge fclk);
        #2 reset = 1'b1;
        repeat (2) @(posedge fclk);
        #2 reset = 1'b0;
        @(negedge fclk);
        chk("abort_hsel", 64'(hmode_select), 64'd5);
        chk("abort_lsel", 64'(lmode_select), 64'd5);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_idx_sel", 64'(idx_sel), 64'd0);
        chk("abort_strobes", 64'({pc_inc, latch_lo_en, latch_hi_en, alu_index_req, fix_hi}), 64'd0);
        dn = 0;
        repeat (16) begin
            dn += int'(done);
            @(negedge fclk);
        end
        chk("abort_no_done", 64'(dn), 64'd0);

        run_access(3'd0, 1'b0, 1'b0, 1'b0, mk(4, 64'({6'o55}), 1, 1, 1, 0, 0, 0, 1'b0));

        repeat (8) @(negedge fclk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
